// File: rtl/ex_div_pkg.sv
// Shared constants and state type for the EX-stage divider.
package ex_div_pkg;

   localparam int unsigned RegBus       = 32;
   localparam int unsigned DoubleRegBus = 64;

   localparam logic [RegBus-1:0] ZeroWord = '0;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

endpackage

// File: rtl/ex_div.sv
// 32-iteration restoring divider for the EX stage; returns {remainder, quotient}
// with a level start / ready handshake and flush cancellation.
module ex_div
   import ex_div_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    signed_div_i,
   input  logic [RegBus-1:0]       opdata1_i,
   input  logic [RegBus-1:0]       opdata2_i,
   input  logic                    start_i,
   input  logic                    annul_i,
   output logic [DoubleRegBus-1:0] result_o,
   output logic                    ready_o
);

   div_state_e              state, state_n;
   logic [5:0]              cnt, cnt_n;
   logic [64:0]             sr, sr_n;
   logic [RegBus-1:0]       divisor, divisor_n;
   logic                    sdiv, sdiv_n;
   logic                    sign1, sign1_n;
   logic                    sign2, sign2_n;
   logic [DoubleRegBus-1:0] result, result_n;
   logic                    ready, ready_n;

   logic [RegBus:0]         diff;
   logic [RegBus-1:0]       abs1, abs2, quo_fix, rem_fix;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DivFree;
         cnt     <= '0;
         sr      <= '0;
         divisor <= ZeroWord;
         sdiv    <= 1'b0;
         sign1   <= 1'b0;
         sign2   <= 1'b0;
         result  <= '0;
         ready   <= DivResultNotReady;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         sr      <= sr_n;
         divisor <= divisor_n;
         sdiv    <= sdiv_n;
         sign1   <= sign1_n;
         sign2   <= sign2_n;
         result  <= result_n;
         ready   <= ready_n;
      end
   end

   // Shift register holds {partial remainder, dividend/quotient, spare LSB};
   // the partial remainder at step k is below 2^(k-1), so bit 64 never matters to the compare.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      sr_n      = sr;
      divisor_n = divisor;
      sdiv_n    = sdiv;
      sign1_n   = sign1;
      sign2_n   = sign2;
      result_n  = result;
      ready_n   = ready;

      abs1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
      abs2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
      diff = {1'b0, sr[63:32]} - {1'b0, divisor};

      quo_fix = (sdiv && (sign1 ^ sign2)) ? (~sr[31:0] + 32'd1) : sr[31:0];
      rem_fix = (sdiv && sign1) ? (~sr[64:33] + 32'd1) : sr[64:33];

      unique case (state)
         DivFree: begin
            if (start_i == DivStart && !annul_i) begin
               if (opdata2_i == ZeroWord) begin
                  state_n = DivByZero;
               end else begin
                  state_n   = DivOn;
                  cnt_n     = '0;
                  sr_n      = {ZeroWord, abs1, 1'b0};
                  divisor_n = abs2;
                  sdiv_n    = signed_div_i;
                  sign1_n   = opdata1_i[31];
                  sign2_n   = opdata2_i[31];
               end
            end
         end
         DivByZero: begin
            state_n  = DivEnd;
            result_n = '0;
            ready_n  = DivResultReady;
         end
         DivOn: begin
            if (annul_i) begin
               state_n = DivFree;
               cnt_n   = '0;
            end else if (cnt != 6'd32) begin
               if (diff[32])
                  sr_n = {sr[63:0], 1'b0};
               else
                  sr_n = {diff[31:0], sr[31:0], 1'b1};
               cnt_n = cnt + 6'd1;
            end else begin
               result_n = {rem_fix, quo_fix};
               ready_n  = DivResultReady;
               state_n  = DivEnd;
               cnt_n    = '0;
            end
         end
         DivEnd: begin
            if (start_i == DivStop) begin
               state_n  = DivFree;
               result_n = '0;
               ready_n  = DivResultNotReady;
            end
         end
         default: state_n = DivFree;
      endcase
   end

   assign result_o = result;
   assign ready_o  = ready;

endmodule
